// File: rtl/start_token_consumer.sv
// rtl/start_token_consumer.sv - pops start tokens and issues ap_start, bounding in-flight iterations
// Optional iteration counter: define START_TOKEN_CONSUMER_ITER_CNT_EN.
module start_token_consumer #(
    parameter int DATA_WIDTH   = 1,
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_WIDTH    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tok_empty_n,
    output logic                  tok_read,
    input  logic [DATA_WIDTH-1:0] tok_dout,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic [DATA_WIDTH-1:0] tok_data,
    output logic                  ap_idle,
    output logic                  err_underflow,
    output logic [31:0]           iter_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH:0] MAX_EXT = (CNT_WIDTH+1)'(MAX_INFLIGHT);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] inflight;
    logic [CNT_WIDTH:0]   inflight_ext;
    logic [CNT_WIDTH:0]   inflight_after_start;
    logic                 accept;
    logic                 done_ok;
    logic                 can_idle_pop;
    logic                 can_chain_pop;

    assign inflight_ext         = {1'b0, inflight};
    assign accept               = (state == ARMED) & ap_ready;
    // A done that arrives with nothing in flight is only legal if it pairs with a same-cycle start.
    assign done_ok              = ap_done & ((inflight != '0) | accept);
    assign inflight_after_start = inflight_ext + (CNT_WIDTH+1)'(1) - (CNT_WIDTH+1)'(ap_done);
    assign can_idle_pop         = inflight_ext < MAX_EXT;
    assign can_chain_pop        = inflight_after_start < MAX_EXT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tok_read) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (ap_ready && !tok_read) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tok_read = 1'b0;
        ap_start = 1'b0;
        case (state)
            IDLE: begin
                tok_read = tok_empty_n & can_idle_pop;
            end
            ARMED: begin
                ap_start = 1'b1;
                tok_read = ap_ready & tok_empty_n & can_chain_pop;
            end
            default: begin
                tok_read = 1'b0;
                ap_start = 1'b0;
            end
        endcase
        // Never pop during reset: the token would be discarded with the rest of the state.
        if (reset) begin
            tok_read = 1'b0;
        end
    end

    assign ap_idle = (state == IDLE) & (inflight == '0) & ~tok_empty_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight      <= '0;
            tok_data      <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (tok_read) begin
                tok_data <= tok_dout;
            end
            case ({accept, done_ok})
                2'b10:   inflight <= inflight + CNT_WIDTH'(1);
                2'b01:   inflight <= inflight - CNT_WIDTH'(1);
                default: inflight <= inflight;
            endcase
            if (ap_done && !done_ok) begin
                err_underflow <= 1'b1;
            end
        end
    end

`ifdef START_TOKEN_CONSUMER_ITER_CNT_EN
    logic [31:0] iter_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            iter_q <= '0;
        end else if (done_ok) begin
            iter_q <= iter_q + 32'd1;
        end
    end

    assign iter_cnt = iter_q;
`else
    assign iter_cnt = '0;
`endif

endmodule
